// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART frame transmitter
package uart_tx_pkg;

  // Defaults kept in step with the receiver's global parameters
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Parity bit from the XOR-reduction of the word: even keeps the total
  // count of ones even, odd inverts it
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - prescale counter producing a pulse at the end of each bit period
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      en_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      bit_done_o
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  // Last cycle of the current bit; prescale_i is never zero while enabled
  assign bit_done_o = en_i && (cnt_q == (prescale_i - ONE));

  // Count 0..prescale-1, wrap at the bit boundary, hold at zero when idle
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !en_i) begin
      cnt_d = '0;
    end else if (bit_done_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, data LSB-first, optional parity, stop
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  tx_state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      accept;
  logic                      bit_done;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clear_i    (accept),
    .en_i       (state_q != IDLE),
    .prescale_i (prescale_q),
    .bit_done_o (bit_done)
  );

  // Next state, frame latching, and the line/busy values for the next cycle
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;
    bit_idx_d  = bit_idx_q;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        if (DATA_VALID && (Prescale != '0)) begin
          accept     = 1'b1;
          data_d     = P_DATA;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          prescale_d = Prescale;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_ONE;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_idx_d];
      PARITY:  tx_d = parity_bit(^data_d, par_typ_d);
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset drops any frame in flight immediately
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  uart_tx_frame #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    int         ps;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     n_pushed = 0;
  int     n_seen   = 0;
  logic   mon_en   = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic pt, input int ps);
    frame_t f;
    f.data = d; f.par_en = pe; f.par_typ = pt; f.ps = ps;
    exp_q.push_back(f);
    n_pushed++;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge CLK);
    while (Busy !== 1'b0 && w < 3000) begin
      @(negedge CLK);
      w++;
    end
    check("idle_wait", (w < 3000), 1);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int ps);
    wait_idle();
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps[5:0]; DATA_VALID = 1'b1;
    push_exp(d, pe, pt, ps);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    check("start_busy", Busy, 1);
    check("start_tx", TX_OUT, 0);
  endtask

  // Monitor: each Busy rise pops one expectation and checks the whole frame
  initial begin : monitor
    logic   busy_prev;
    logic   bits [0:15];
    frame_t f;
    int     nb, cyc, hold_err, k;
    busy_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (Busy === 1'b1 && busy_prev === 1'b0 && mon_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          f = exp_q.pop_front();
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
          nb = 9;
          if (f.par_en) begin
            bits[nb] = f.par_typ ? ~(^f.data) : (^f.data);
            nb++;
          end
          bits[nb] = 1'b1;
          nb++;
          cyc = 0;
          hold_err = 0;
          while (Busy === 1'b1 && cyc < 2000) begin
            k = cyc / f.ps;
            if (k < nb) begin
              if (TX_OUT !== bits[k]) hold_err++;
              if ((cyc % f.ps) == (f.ps / 2))
                check($sformatf("bit%0d_d%02h", k, f.data), TX_OUT, bits[k]);
            end else begin
              hold_err++;
            end
            cyc++;
            @(negedge CLK);
          end
          check($sformatf("busy_len_d%02h", f.data), cyc, nb * f.ps);
          check("hold_err", hold_err, 0);
          check("idle_tx_after", TX_OUT, 1);
          n_seen++;
        end
      end
      busy_prev = Busy;
    end
  end

  initial begin : stim
    int w, gap, busy_seen, low_seen;
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", Busy, 0);
    @(negedge CLK);
    RST = 1'b0;

    send(8'hA5, 1'b1, 1'b0, 8);
    send(8'h01, 1'b1, 1'b1, 16);
    send(8'h03, 1'b1, 1'b1, 16);
    send(8'hFF, 1'b0, 1'b0, 4);

    // Back-to-back with DATA_VALID held; inputs churn during the first frame
    wait_idle();
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8; DATA_VALID = 1'b1;
    push_exp(8'h3C, 1'b0, 1'b0, 8);
    @(posedge CLK); #1;
    check("b2b_start_busy", Busy, 1);
    P_DATA = 8'hC3; Prescale = 6'd3; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    repeat (20) @(negedge CLK);
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    push_exp(8'hC3, 1'b0, 1'b0, 8);
    w = 0;
    while (Busy !== 1'b0 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    gap = 0;
    while (Busy === 1'b0 && gap < 10) begin
      gap++;
      @(negedge CLK);
    end
    check("b2b_gap", gap, 1);
    DATA_VALID = 1'b0;

    // Requests while busy are dropped
    send(8'h69, 1'b1, 1'b0, 4);
    repeat (5) begin
      repeat (3) @(negedge CLK);
      P_DATA = 8'hFF; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
    end

    // Reset 40 cycles into a frame abandons it
    wait_idle();
    mon_en = 1'b0;
    P_DATA = 8'h5A; PAR_EN = 1'b0; Prescale = 6'd8; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    repeat (39) @(posedge CLK);
    @(negedge CLK);
    check("abort_pre_busy", Busy, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("abort_tx", TX_OUT, 1);
    check("abort_busy", Busy, 0);
    @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;
    send(8'h5A, 1'b0, 1'b0, 8);

    // Prescale of zero never starts a frame
    wait_idle();
    Prescale = 6'd0; P_DATA = 8'h12; DATA_VALID = 1'b1;
    busy_seen = 0; low_seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (Busy !== 1'b0) busy_seen++;
      if (TX_OUT !== 1'b1) low_seen++;
    end
    check("ps0_busy", busy_seen, 0);
    check("ps0_tx", low_seen, 0);
    DATA_VALID = 1'b0;

    // Reset wins over a simultaneous request
    @(negedge CLK);
    RST = 1'b1; DATA_VALID = 1'b1; Prescale = 6'd4;
    @(posedge CLK); #1;
    check("rst_dv_busy", Busy, 0);
    check("rst_dv_tx", TX_OUT, 1);
    @(negedge CLK);
    RST = 1'b0; DATA_VALID = 1'b0;

    // Maximum prescale and randomized frames
    send(8'h96, 1'b1, 1'b1, 63);
    for (int i = 0; i < 64; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(1, 12)));
    end

    wait_idle();
    repeat (3) @(negedge CLK);
    check("queue_empty", exp_q.size(), 0);
    check("frames_seen", n_seen, n_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Serial UART transmitter: the stage directly upstream of the UART receiver, driving the line that the receiver samples. It accepts one parallel word per handshake and serialises it as a frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit. Each bit is held for Prescale clock cycles, so it pairs with the receiver's oversampling scheme on a shared CLK. It is also the stimulus-side reference for loopback checks against the receiver.

Parameters:
DATA_WIDTH, 8, width of the parallel data word / number of data bits per frame
PRESCALE_WIDTH, 6, width of the Prescale input (bit period in CLK cycles)

Ports:
CLK  in  1  single system clock, rising-edge
RST  in  1  synchronous, active-high reset
P_DATA  in  DATA_WIDTH  word to transmit
DATA_VALID  in  1  request; accepted only in a cycle where Busy=0 and Prescale!=0
PAR_EN  in  1  1 = insert parity bit after the data bits
PAR_TYP  in  1  0 = even parity, 1 = odd parity
Prescale  in  PRESCALE_WIDTH  CLK cycles per bit
TX_OUT  out  1  serial line, idle high
Busy  out  1  frame in progress

Behaviour:
- One clock (CLK). Reset is synchronous, active-high (RST). All outputs are registered.
- Reset: TX_OUT=1, Busy=0, FSM=IDLE, counters=0. Applies at the next CLK edge, including mid-frame. A frame in flight is abandoned and the line returns to idle-high with no partial stop bit.
- Accept: the rising edge where DATA_VALID=1, Busy=0 and Prescale!=0 (registered value of the current inputs).
  - At that edge, latch P_DATA, PAR_EN, PAR_TYP and Prescale.
  - Input changes after acceptance have no effect on the current frame.
- DATA_VALID while Busy=1 is ignored, with no queuing. DATA_VALID with Prescale=0 is ignored, and the block stays IDLE.
- FSM states: IDLE -> START -> DATA -> (PARITY if PAR_EN latched) -> STOP -> IDLE.
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT=data[bit_idx], with bit_idx 0..DATA_WIDTH-1.
  - PARITY: TX_OUT = ^data (even) or ~^data (odd).
  - STOP: TX_OUT=1.
  - Busy=1 in all states other than IDLE.
- Bit timing:
  - A prescale counter counts 0..Prescale_latched-1.
  - A state or bit advances when the counter equals Prescale_latched-1; the counter then wraps to 0.
  - bit_idx wraps/clears on leaving DATA.
- Latency: START is visible on TX_OUT in the cycle after the accept edge.
- Frame length = (2 + DATA_WIDTH + PAR_EN) * Prescale cycles of Busy=1.
- Back-to-back: after the last STOP cycle the FSM enters IDLE for exactly one cycle (Busy=0). A request held high is accepted on that edge. The minimum inter-frame gap is 1 cycle of TX_OUT=1.
- Counter widths:
  - prescale counter: PRESCALE_WIDTH bits.
  - bit_idx: $clog2(DATA_WIDTH) bits, minimum 1.
  - No overflow is possible for Prescale up to 2^PRESCALE_WIDTH-1.
- RST and DATA_VALID high in the same cycle: reset wins, and the request is not accepted.

Decomposition:
- Shared package uart_tx_pkg:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP)
  - parity constants PAR_EVEN=0, PAR_ODD=1
  - default DATA_WIDTH/PRESCALE_WIDTH constants, aligned with the receiver's global params package
- One sub-module, uart_tx_bit_timer: prescale counter with a load/clear input and a one-cycle bit_done pulse.
- FSM, shift/index logic and parity stay in the top level.

Test Plan:
- 0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,0(parity),1; each held 8 cycles; Busy high for exactly 88 cycles; START visible 1 cycle after accept.
- 0x01, PAR_EN=1, PAR_TYP=1, Prescale=16 -> parity bit=0; 11 bits x 16 = 176 Busy cycles. Repeat with 0x03 -> parity bit=1.
- 0xFF, PAR_EN=0, Prescale=4 -> frame 0,1x8,1; 40 Busy cycles; no parity slot.
- DATA_VALID held high with 0x3C then 0xC3, Prescale=8, PAR_EN=0 -> second frame accepted on the single idle cycle; gap exactly 1 cycle of TX_OUT=1. P_DATA/Prescale changes mid-frame do not alter the first frame. Pulses while Busy=1 produce no extra frames.
- RST asserted 40 cycles into a 0x5A frame -> next edge TX_OUT=1, Busy=0; a subsequent 0x5A request completes a full, correct frame.
- Prescale=0 with DATA_VALID=1 -> no accept; Busy stays 0 and TX_OUT stays 1. Loopback of 256 random words into the receiver DUT (same Prescale/parity) -> every word recovered with no parity or stop error.
